// File: rtl/hash_byte_feeder_if.sv
// Byte-streaming handshake between the feeder (master) and the hash core (slave).
// The feeder presents bytes with F_dr and the core accepts them with F_rtr; the digest returns on R_h with H_ready.
interface hash_byte_feeder_if;
  logic        start;
  logic [7:0]  Byte;
  logic        F_dr;
  logic        End_of_File;
  logic        F_rtr;
  logic [31:0] R_h;
  logic        H_ready;

  modport master (
    output start, Byte, F_dr, End_of_File,
    input  F_rtr, R_h, H_ready
  );

  modport slave (
    input  start, Byte, F_dr, End_of_File,
    output F_rtr, R_h, H_ready
  );
endinterface

// File: rtl/hash_byte_feeder.sv
// Buffers a host message, streams it byte-by-byte into the hash core, then waits for
// the digest and reports done, or err on an empty go or a digest timeout.
module hash_byte_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  go,
  output logic                  full,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           digest,
  hash_byte_feeder_if.master    hb
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, SEND, WAIT_H} state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [TW-1:0]   timer_reg;
  logic            start_reg;
  logic            f_dr_reg;
  logic            eof_reg;
  logic            done_reg;
  logic            err_reg;
  logic [7:0]      byte_reg;
  logic [31:0]     digest_reg;

  logic [7:0]      mem [DEPTH];

  logic            wr_accept;
  logic            xfer;
  logic [AW-1:0]   rd_ptr_next;

  // go wins over a write in the same cycle, so the message is frozen at go time.
  assign wr_accept   = (state_reg == IDLE) && wr_en && !go && (count_reg < CW'(DEPTH));
  assign xfer        = f_dr_reg && hb.F_rtr;
  assign rd_ptr_next = rd_ptr_reg + AW'(1);

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[count_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      timer_reg  <= '0;
      start_reg  <= 1'b0;
      f_dr_reg   <= 1'b0;
      eof_reg    <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      byte_reg   <= '0;
      digest_reg <= '0;
    end else begin
      start_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (go) begin
            if (count_reg == '0) begin
              err_reg <= 1'b1;
            end else begin
              start_reg <= 1'b1;
              state_reg <= START;
            end
          end else if (wr_accept) begin
            count_reg <= count_reg + CW'(1);
          end
        end
        START: begin
          rd_ptr_reg <= '0;
          byte_reg   <= mem[0];
          f_dr_reg   <= 1'b1;
          eof_reg    <= (count_reg == CW'(1));
          state_reg  <= SEND;
        end
        SEND: begin
          // Byte/F_dr/End_of_File only move on an accepted transfer, never retracted.
          if (xfer) begin
            if (eof_reg) begin
              f_dr_reg  <= 1'b0;
              eof_reg   <= 1'b0;
              timer_reg <= '0;
              state_reg <= WAIT_H;
            end else begin
              rd_ptr_reg <= rd_ptr_next;
              byte_reg   <= mem[rd_ptr_next];
              eof_reg    <= (CW'(rd_ptr_next) == count_reg - CW'(1));
            end
          end
        end
        WAIT_H: begin
          if (hb.H_ready) begin
            digest_reg <= hb.R_h;
            done_reg   <= 1'b1;
            count_reg  <= '0;
            state_reg  <= IDLE;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            err_reg   <= 1'b1;
            count_reg <= '0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign full           = (count_reg == CW'(DEPTH));
  assign busy           = (state_reg != IDLE);
  assign done           = done_reg;
  assign err            = err_reg;
  assign digest         = digest_reg;
  assign hb.start       = start_reg;
  assign hb.Byte        = byte_reg;
  assign hb.F_dr        = f_dr_reg;
  assign hb.End_of_File = eof_reg;

endmodule

// File: tb/tb_hash_byte_feeder.sv
// Bench for hash_byte_feeder: table of messages with F_rtr patterns and digest outcomes,
// a scoreboard queue of expected bytes checked by a monitor, plus hand-written corner sequences.
module tb_hash_byte_feeder;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        go = 1'b0;
  logic        full, busy, done, err;
  logic [31:0] digest;

  hash_byte_feeder_if hif ();

  hash_byte_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .go      (go),
    .full    (full),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .digest  (digest),
    .hb      (hif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       eof;
  } xfer_t;

  typedef struct {
    int          len;
    logic [7:0]  base;
    logic [15:0] pat;
    int          plen;
    logic        go_wr;
    logic        use_h;
    logic [31:0] rh;
    logic [31:0] exp_digest;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  int    start_cnt = 0;
  xfer_t byte_q[$];
  bit    rtr_q[$];
  vec_t  vecs[5];

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_cycles(input int len, input logic [15:0] pat, input int plen);
    int ones = 0;
    int c = 0;
    while (ones < len) begin
      if (c < plen) ones += int'(pat[c]);
      else ones += 1;
      c++;
    end
    return c;
  endfunction

  // F_rtr driver: replays queued pattern bits, otherwise ready.
  initial begin
    hif.F_rtr = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rtr_q.size() != 0) hif.F_rtr = rtr_q.pop_front();
      else hif.F_rtr = 1'b1;
    end
  end

  // Monitor: scoreboard pops on each accepted byte, and stalled bytes must stay put.
  initial begin
    logic       pv;
    logic [7:0] pb;
    logic       pe;
    xfer_t      x;
    pv = 1'b0;
    pb = 8'h00;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (hif.start) start_cnt++;
        if (pv) begin
          check_bit("hold_fdr", hif.F_dr, 1'b1);
          check32("hold_byte", {24'h0, hif.Byte}, {24'h0, pb});
          check_bit("hold_eof", hif.End_of_File, pe);
        end
        if (hif.F_dr && hif.F_rtr) begin
          check_bit("byte_expected", byte_q.size() != 0, 1'b1);
          if (byte_q.size() != 0) begin
            x = byte_q.pop_front();
            check32("byte", {24'h0, hif.Byte}, {24'h0, x.data});
            check_bit("eof", hif.End_of_File, x.eof);
          end
        end
        pv = hif.F_dr && !hif.F_rtr;
        pb = hif.Byte;
        pe = hif.End_of_File;
      end
    end
  end

  task automatic write_msg(input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      if (i < DEPTH) byte_q.push_back('{base + 8'(i), (i == ((len < DEPTH ? len : DEPTH) - 1))});
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    step();
    write_msg(v.len, v.base);
    @(negedge clk);
    check_bit("full", full, v.len >= DEPTH);
    step();
    go      = 1'b1;
    wr_en   = v.go_wr;
    wr_data = 8'hEE;
    step();
    go    = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    check_bit("start_pulse", hif.start, 1'b1);
    check_bit("busy_start", busy, 1'b1);
    check_bit("fdr_in_start", hif.F_dr, 1'b0);
    for (int c = 0; c < v.plen; c++) rtr_q.push_back(v.pat[c]);
    @(negedge clk);
    check_bit("start_one_cycle", hif.start, 1'b0);
    check_bit("first_fdr", hif.F_dr, 1'b1);
    n = 1;
    while (!(hif.F_dr && hif.F_rtr && hif.End_of_File) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check32("send_cycles", n, exp_cycles(v.len < DEPTH ? v.len : DEPTH, v.pat, v.plen));
    if (v.use_h) begin
      @(posedge clk);
      #1;
      hif.H_ready = 1'b1;
      hif.R_h     = v.rh;
      step();
      hif.H_ready = 1'b0;
      hif.R_h     = 32'h0;
      @(negedge clk);
      check_bit("done", done, 1'b1);
      check_bit("err_with_done", err, 1'b0);
      check32("digest", digest, v.exp_digest);
      check_bit("busy_after_done", busy, 1'b0);
      check_bit("full_after_done", full, 1'b0);
      check_bit("fdr_after_done", hif.F_dr, 1'b0);
      @(negedge clk);
      check_bit("done_one_cycle", done, 1'b0);
    end else begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (done) check_bit("done_in_timeout", done, 1'b0);
      end while (!err && n < 50);
      check32("timeout_cycles", n, TIMEOUT + 1);
      check32("digest_kept", digest, v.exp_digest);
      check_bit("busy_after_err", busy, 1'b0);
      check_bit("done_with_err", done, 1'b0);
      @(negedge clk);
      check_bit("err_one_cycle", err, 1'b0);
    end
    check32("queue_drained", byte_q.size(), 0);
    $display("[TB] vector %0d: len=%0d send_cycles=%0d digest=%h", idx, v.len, n, digest);
  endtask

  initial begin
    int   sc;
    vec_t rv;
    hif.H_ready = 1'b0;
    hif.R_h     = 32'h0;

    vecs[0] = '{3,  8'h61, 16'h0000, 0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{3,  8'h61, 16'h0019, 5, 1'b0, 1'b1, 32'h12345678, 32'h12345678};
    vecs[2] = '{1,  8'hA0, 16'h0000, 0, 1'b1, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[3] = '{5,  8'h10, 16'h000A, 4, 1'b0, 1'b0, 32'h00000000, 32'hCAFEF00D};
    vecs[4] = '{16, 8'h80, 16'h0000, 0, 1'b0, 1'b1, 32'h0BADF00D, 32'h0BADF00D};

    repeat (3) @(negedge clk);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_full", full, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check32("rst_digest", digest, 32'h0);
    check_bit("rst_start", hif.start, 1'b0);
    check_bit("rst_fdr", hif.F_dr, 1'b0);
    check_bit("rst_eof", hif.End_of_File, 1'b0);
    check32("rst_byte", {24'h0, hif.Byte}, 32'h0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Empty go: err only, never start; stray H_ready in IDLE is ignored.
    step();
    sc = start_cnt;
    go = 1'b1;
    step();
    go = 1'b0;
    @(negedge clk);
    check_bit("empty_go_err", err, 1'b1);
    check_bit("empty_go_start", hif.start, 1'b0);
    check_bit("empty_go_busy", busy, 1'b0);
    @(negedge clk);
    check_bit("empty_go_err_pulse", err, 1'b0);
    step();
    hif.H_ready = 1'b1;
    hif.R_h     = 32'hFFFFFFFF;
    step();
    hif.H_ready = 1'b0;
    @(negedge clk);
    check_bit("idle_hready_done", done, 1'b0);
    check32("idle_hready_digest", digest, 32'h0BADF00D);
    check32("empty_go_no_start", start_cnt, sc);
    $display("[TB] empty go: err seen, start count unchanged %0d", start_cnt);

    // Overflow then asynchronous reset in the middle of SEND.
    step();
    write_msg(DEPTH + 2, 8'hC0);
    @(negedge clk);
    check_bit("overflow_full", full, 1'b1);
    step();
    go = 1'b1;
    step();
    go = 1'b0;
    repeat (4) @(negedge clk);
    check_bit("midsend_fdr", hif.F_dr, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    check_bit("abort_fdr", hif.F_dr, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_full", full, 1'b0);
    check_bit("abort_eof", hif.End_of_File, 1'b0);
    check32("abort_digest", digest, 32'h0);
    $display("[TB] reset mid-send: %0d bytes left undelivered", byte_q.size());
    byte_q.delete();
    rtr_q.delete();
    step();
    rst_n = 1'b1;

    rv = '{2, 8'h55, 16'h0002, 2, 1'b0, 1'b1, 32'hA5A5F00F, 32'hA5A5F00F};
    run_vec(rv, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
endmodule
